csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 16-bit combinational carry-select adder.
- Operand width is split into BLK-bit carry-select blocks, with one block resolved per pipeline stage.
- Adds a valid/ready handshake with back-pressure, a subtract mode and a signed-overflow flag.
- Sits in the datapath library as the reusable wide adder for accumulator and ALU blocks.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of BLK.
- BLK, 4: carry-select block width in bits, BLK >= 2.
- NSTG, WIDTH/BLK: derived number of pipeline stages. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in. Ignored when sub=1.
- sub  in  1  0: a+b+cin. 1: a-b, computed as a+~b+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  signed overflow: the carry into the MSB XOR the carry out of the MSB.

Behaviour:
- Reset (async assert, release sync to clk):
  - All stage registers, valid bits, sum, cout, ovf and out_valid go to 0.
  - in_ready is 1 after reset.
- Operand preparation, at input:
  - bb = sub ? ~b : b
  - c0 = sub ? 1 : cin
  - All three are registered together with a into stage 0.
- Stage k (k = 0..NSTG-1) handles bits [k*BLK +: BLK]:
  - Precomputes s0 = a_blk + bb_blk + 0 and s1 = a_blk + bb_blk + 1, each BLK+1 bits.
  - Selects s0 or s1 with the carry registered from stage k-1 (c0 for k=0).
  - Writes the BLK-bit result into its slice of the partial-sum register and registers the carry for stage k+1.
  - Stage NSTG-1 also records the carry into the MSB for ovf.
- Operand skew:
  - Upper operand slices not yet consumed travel down the pipe alongside the partial sum.
  - Resolved lower slices travel forward unchanged.
- Latency:
  - Exactly NSTG clk cycles from acceptance (in_valid && in_ready) to out_valid with the matching result, when out_ready is held 1.
  - Throughput is one beat per cycle.
- Stage valid bits:
  - Each stage carries a valid bit; bubbles propagate as invalid.
  - Data registers of invalid stages are don't-care, but must not toggle sum/cout/ovf while out_valid=0.
- Stall:
  - adv = !out_valid || out_ready.
  - When adv=0, every stage register holds, including its valid bit.
  - in_ready = adv, which is combinational from out_ready and out_valid.
  - A beat offered while in_ready=0 is not taken; the source holds it.
  - sum/cout/ovf stay stable while out_valid && !out_ready.
- Simultaneous accept and drain: in the same cycle, when adv=1, the pipe shifts by one. No beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded. The first out_valid after reset corresponds to the first beat accepted after reset.
- Wrap-around: sum is modulo 2^WIDTH. The carry is reported only on cout.
- Arithmetic must be bit-exact against {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), evaluated in WIDTH+1 bits.
- Elaboration: WIDTH % BLK != 0 or BLK < 2 is a fatal elaboration error, implemented as a generate-time $error.

Test Plan:
All scenarios use WIDTH=16, BLK=4, latency 4, and out_ready=1 unless stated.
- Reset and basic add:
  - Stimulus: deassert rst_n; send a=0, b=0, cin=1, sub=0; then a=14, b=1, cin=1; then a=999, b=0, cin=1 on consecutive cycles.
  - Required: out_valid rises 4 cycles after the first accept; results are sum=0x0001, 0x0010, 0x03E8, each with cout=0, ovf=0, on back-to-back cycles.
- Carry ripple across all blocks:
  - Stimulus: a=0xFFFF, b=0, cin=1.
  - Required: sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - Stimulus: a=5, b=14, sub=1, cin=1 (cin must be ignored).
  - Required: sum=0xFFF7, cout=0, ovf=0.
  - Stimulus: a=14, b=5, sub=1.
  - Required: sum=0x0009, cout=1.
- Back-pressure:
  - Stimulus: stream 8 beats a=i, b=i (i=1..8); hold out_ready=0 for 5 cycles once the first result is valid, then release.
  - Required: in_ready=0 throughout the stall; sum held at 0x0002; afterwards the outputs are 2,4,...,16 in order, with no loss or duplication.
- Reset mid-flight:
  - Stimulus: accept 3 beats, pulse rst_n low for 1 cycle before any output, then send a=1, b=2.
  - Required: out_valid=0 immediately on reset assertion; the only result seen afterwards is sum=0x0003, 4 cycles after its accept.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// valid/ready handshake with a global stall, carry-out and signed-overflow flags.
module csel_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4,
   localparam int NSTG = WIDTH / BLK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if ((WIDTH % BLK) != 0 || BLK < 2) begin : g_param_check
      $error("csel_adder_pipe: WIDTH must be a multiple of BLK and BLK >= 2");
   end

   // Rank 0 holds the prepared operands; rank k+1 holds the result of stage k.
   logic [NSTG:0]      vld_q;
   logic [WIDTH-1:0]   a_q  [NSTG];
   logic [WIDTH-1:0]   bb_q [NSTG];
   logic [WIDTH-1:0]   ps_q [NSTG+1];
   logic [NSTG:0]      c_q;
   logic               ovf_q;

   logic [BLK:0]       s0_d  [NSTG];
   logic [BLK:0]       s1_d  [NSTG];
   logic [BLK:0]       sel_d [NSTG];
   logic [WIDTH-1:0]   ps_d  [NSTG];
   logic [NSTG-1:0]    c_d;
   logic               ovf_d;
   logic               adv;

   assign adv       = !vld_q[NSTG] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[NSTG];
   assign sum       = ps_q[NSTG];
   assign cout      = c_q[NSTG];
   assign ovf       = ovf_q;

   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         s0_d[k]  = {1'b0, a_q[k][k*BLK +: BLK]} + {1'b0, bb_q[k][k*BLK +: BLK]};
         s1_d[k]  = s0_d[k] + {{BLK{1'b0}}, 1'b1};
         sel_d[k] = c_q[k] ? s1_d[k] : s0_d[k];
         ps_d[k]  = ps_q[k];
         ps_d[k][k*BLK +: BLK] = sel_d[k][BLK-1:0];
         c_d[k]   = sel_d[k][BLK];
      end
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      ovf_d = a_q[NSTG-1][WIDTH-1] ^ bb_q[NSTG-1][WIDTH-1]
            ^ sel_d[NSTG-1][BLK-1] ^ sel_d[NSTG-1][BLK];
   end

   // Data ranks only load behind a valid beat so outputs never toggle on bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < NSTG; k++) begin
            a_q[k]  <= '0;
            bb_q[k] <= '0;
         end
         for (int k = 0; k <= NSTG; k++) begin
            ps_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q <= {vld_q[NSTG-1:0], in_valid};
         if (in_valid) begin
            a_q[0]  <= a;
            bb_q[0] <= sub ? ~b : b;
            c_q[0]  <= sub | cin;
            ps_q[0] <= '0;
         end
         for (int k = 0; k < NSTG-1; k++) begin
            if (vld_q[k]) begin
               a_q[k+1]  <= a_q[k];
               bb_q[k+1] <= bb_q[k];
            end
         end
         for (int k = 0; k < NSTG; k++) begin
            if (vld_q[k]) begin
               ps_q[k+1] <= ps_d[k];
               c_q[k+1]  <= c_d[k];
            end
         end
         if (vld_q[NSTG-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe (WIDTH=16, BLK=4): vector table plus hand-written
// back-pressure and mid-flight reset sequences, checked through a scoreboard queue.
module tb_csel_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [17:0] exp;
      int          acc;
      bit          lat;
      int          id;
   } sb_t;

   vec_t tbl[12];
   sb_t  sbq[$];
   sb_t  mon_e;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_push = 0;
   int   n_out  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: every drained beat is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got sum=0x%0h with nothing expected, required no output", sum);
         end else begin
            mon_e = sbq.pop_front();
            chk($sformatf("result_%0d {cout,ovf,sum}", mon_e.id), 32'({cout, ovf, sum}), 32'(mon_e.exp));
            if (mon_e.lat) chk($sformatf("latency_%0d", mon_e.id), 32'(cyc - mon_e.acc), 32'd4);
         end
      end
   end

   // Offers one beat and waits (bounded) for it to be accepted.
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic sv, input bit push, input logic [15:0] es,
                       input logic eco, input logic eov, input bit lat, input int id);
      logic acc;
      sb_t  e;
      acc      = 1'b0;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      cin      = cv;
      sub      = sv;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc && push) begin
            e.exp = {eco, eov, es};
            e.acc = cyc + 1;
            e.lat = lat;
            e.id  = id;
            sbq.push_back(e);
            n_push++;
         end
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout_%0d: got in_ready=0 for 100 cycles, required 1", id);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      for (t = 0; t < 60 && sbq.size() != 0; t++) @(posedge clk);
      #1;
      chk({name, "_drain_pending"}, 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      tbl[1]  = '{16'd14,   16'd1,    1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
      tbl[2]  = '{16'd999,  16'd0,    1'b1, 1'b0, 16'h03E8, 1'b0, 1'b0};
      tbl[3]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[5]  = '{16'd5,    16'd14,   1'b1, 1'b1, 16'hFFF7, 1'b0, 1'b0};
      tbl[6]  = '{16'd14,   16'd5,    1'b0, 1'b1, 16'h0009, 1'b1, 1'b0};
      tbl[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[9]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[11] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst_n     = 1'b0;
      out_ready = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_sum",       32'(sum),       32'd0);
      chk("reset_cout",      32'(cout),      32'd0);
      chk("reset_ovf",       32'(ovf),       32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back vectors, each checked for value and 4-cycle latency.
      for (int i = 0; i < 12; i++)
         send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1,
              tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1, i);
      idle();
      drain("table");

      // Back-pressure: stall 5 cycles once the first result is valid.
      fork
         begin
            for (int i = 1; i <= 8; i++)
               send(16'(i), 16'(i), 1'b0, 1'b0, 1'b1, 16'(2 * i), 1'b0, 1'b0, 1'b0, 100 + i);
            idle();
         end
         begin
            int t;
            for (t = 0; t < 40; t++) begin
               @(posedge clk);
               #1;
               if (out_valid) break;
            end
            if (t == 40) begin
               n_chk++;
               n_fail++;
               $display("FAIL bp_first_valid: got out_valid=0 for 40 cycles, required 1");
            end
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               chk($sformatf("bp_in_ready_%0d", s),  32'(in_ready),  32'd0);
               chk($sformatf("bp_out_valid_%0d", s), 32'(out_valid), 32'd1);
               chk($sformatf("bp_sum_hold_%0d", s),  32'(sum),       32'h0002);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("backpressure");

      // Mid-flight reset: three beats are discarded, only the post-reset beat returns.
      for (int i = 0; i < 3; i++)
         send(16'(10 + i), 16'(20 + i), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 200 + i);
      idle();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(16'd1, 16'd2, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 300);
      idle();
      drain("midreset");
      repeat (8) @(posedge clk);
      #1;
      chk("output_count", 32'(n_out), 32'(n_push));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
